// File: rtl/fir_pkg.sv
// Shared defaults, controller state encoding and reset coefficient profile
// for the time-shared FIR sequencer.
package fir_pkg;

    localparam int DW_DEF    = 8;
    localparam int NTAPS_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    // Reset coefficient ramp: tap i gets weight i+1.
    function automatic int unsigned default_coef(input int unsigned idx);
        return idx + 1;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Single multiply-accumulate unit; clear has priority over enable so a new
// sample always starts from zero.
module fir_mac #(
    parameter int DW   = 8,
    parameter int ACCW = 18
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic [DW-1:0]   a_i,
    input  logic [DW-1:0]   b_i,
    output logic [ACCW-1:0] acc_o
);

    logic [2*DW-1:0] prod;
    logic [ACCW-1:0] acc_q;
    logic [ACCW-1:0] acc_d;

    assign prod = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + {{(ACCW-2*DW){1'b0}}, prod};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequential FIR: one sample accepted in IDLE, one tap per cycle in MAC,
// result held in OUT until the consumer takes it.
module fir_seq_ctrl
    import fir_pkg::*;
#(
    parameter int  NTAPS = NTAPS_DEF,
    parameter int  DW    = DW_DEF,
    localparam int TW    = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    input  logic          cfg_we,
    input  logic [TW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_data,
    output logic          busy,
    output logic [1:0]    dbg_state_o
);

    localparam int ACCW = 2*DW + TW;

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; in_ready depends only on state, and out_data is stable
    // for as long as out_valid is high and out_ready is low.

    state_e          state_q;
    state_e          state_d;
    logic [DW-1:0]   r_q [NTAPS];
    logic [DW-1:0]   c_q [NTAPS];
    logic [TW-1:0]   tap_q;
    logic            accept;
    logic            mac_en;
    logic            last_tap;
    logic [ACCW-1:0] acc;

    assign last_tap = (tap_q == TW'(NTAPS-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_MAC;
            ST_MAC:  if (last_tap) state_d = ST_OUT;
            ST_OUT:  if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_OUT);
        busy      = (state_q != ST_IDLE);
        mac_en    = (state_q == ST_MAC);
        accept    = in_valid && in_ready;
    end

    // Coefficient writes land at the accept edge too, so they are already
    // visible when MAC starts reading them on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_q[i] <= '0;
                c_q[i] <= DW'(default_coef(unsigned'(i)));
            end
            tap_q <= '0;
        end else begin
            if (accept) begin
                r_q[0] <= in_data;
                for (int i = 1; i < NTAPS; i++) begin
                    r_q[i] <= r_q[i-1];
                end
                tap_q <= '0;
            end else if (mac_en) begin
                tap_q <= tap_q + TW'(1);
            end
            if (cfg_we && (state_q == ST_IDLE) && (int'(cfg_addr) < NTAPS)) begin
                c_q[cfg_addr] <= cfg_data;
            end
        end
    end

    fir_mac #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .en_i  (mac_en),
        .a_i   (r_q[tap_q]),
        .b_i   (c_q[tap_q]),
        .acc_o (acc)
    );

    assign out_data    = acc[DW-1:0];
    assign dbg_state_o = state_q;

endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 SHALL have parameter NTAPS, default 4, number of taps.
REQ-002 SHALL have parameter DW, default 8, sample/coefficient/output width.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): sample handshake.
REQ-006 SHALL have port in_data, input, DW, input sample, unsigned.
REQ-007 SHALL have ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-008 SHALL have port out_data, output, DW, filter result, unsigned.
REQ-009 SHALL have ports cfg_we (input, 1), cfg_addr (input, clog2(NTAPS)) and cfg_data (input, DW): coefficient write.
REQ-010 SHALL have port busy, output, 1, high when state is not IDLE.

Function
REQ-011 SHALL time-share one DW x DW multiplier and one accumulator across all taps, one tap per cycle.
REQ-012 SHALL implement states IDLE, MAC and OUT.
REQ-013 SHALL drive in_ready high only in IDLE; out_valid high only in OUT.
REQ-014 IDLE, in_valid & in_ready: SHALL shift the delay line (r[0]<=in_data, r[i]<=r[i-1]), clear acc and tap counter, go to MAC.
REQ-015 MAC: SHALL add r[tap]*c[tap] to acc each cycle and increment tap; after tap NTAPS-1, go to OUT.
REQ-016 Latency: out_valid SHALL assert exactly NTAPS cycles after the accepting edge.
REQ-017 Accumulator width SHALL be 2*DW+clog2(NTAPS); out_data SHALL be acc[DW-1:0] (modulo 2^DW wrap, no saturation).
REQ-018 OUT: out_data SHALL hold stable while out_valid=1 and out_ready=0; on out_ready=1 go to IDLE.
REQ-019 Maximum throughput: one sample per NTAPS+2 cycles when out_ready is held high.
REQ-020 cfg_we SHALL write c[cfg_addr]<=cfg_data only in IDLE; it SHALL be ignored in MAC and OUT.
REQ-021 A cfg write and a sample accept in the same IDLE cycle SHALL both take effect; the new coefficient applies to that sample.
REQ-022 in_data SHALL be ignored while in_ready=0; the delay line SHALL change only on an accept.

Reset
REQ-023 rst SHALL force IDLE; clear delay line, acc and tap counter to 0.
REQ-024 rst SHALL load coefficients c[i]=i+1 (1,2,3,4 at default).
REQ-025 After rst, SHALL hold in_ready=1, out_valid=0, out_data=0 and busy=0.
REQ-026 rst asserted during MAC or OUT SHALL abort the computation with no output.

Structure
REQ-027 Package fir_pkg SHALL hold DW/NTAPS defaults, the state enum and the default-coefficient function.
REQ-028 Sub-module fir_mac SHALL be the multiply-accumulate unit (clear, enable, operands, acc out).

Verification
REQ-029 Impulse 1 followed by zeros, out_ready=1 -> out_data 1,2,3,4,0.
REQ-030 Four samples 0xFF, default coefficients -> 0xFF, 0xFD, 0xFA, 0xF6 (wrap).
REQ-031 Write c[2]=0x10 in IDLE, then impulse 1 -> 1,2,0x10,4; write in MAC -> ignored.
REQ-032 out_ready=0 for 5 cycles -> out_data stable, in_ready=0, no sample lost; completes on release.
REQ-033 rst in the second MAC cycle -> IDLE next cycle, out_valid never asserts, next impulse -> 1,2,3,4.
REQ-034 Accept edge at cycle k -> out_valid first high in cycle k+NTAPS; in_ready low in between.
